// File: rtl/uart_ns_rx_fifo_pkg.sv
// Shared UART receive-path constants, trigger-level enum and level decode.
package uart_ns_rx_fifo_pkg;

   localparam int UART_DATA_SIZE         = 8;
   localparam int UART_RX_FIFO_DEPTH     = 16;
   localparam int UART_FIFO_FLUSH_RX_BIT = 1;

   typedef enum logic [1:0] {
      TRIG_1  = 2'd0,
      TRIG_4  = 2'd1,
      TRIG_8  = 2'd2,
      TRIG_14 = 2'd3
   } type_uart_rx_trig_e;

   function automatic logic [4:0] trig_entries(input type_uart_rx_trig_e sel);
      logic [4:0] lvl;
      case (sel)
         TRIG_4:  lvl = 5'd4;
         TRIG_8:  lvl = 5'd8;
         TRIG_14: lvl = 5'd14;
         default: lvl = 5'd1;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/uart_ns_rx_fifo_if.sv
// Receive FIFO bus: receiver push side, register-file pop/control side, status.
interface uart_ns_rx_fifo_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              wr_valid_i;
   logic [DATA_W-1:0] wr_data_i;
   logic              wr_frame_err_i;
   logic              rd_pop_i;
   logic [DATA_W-1:0] rd_data_o;
   logic              rd_frame_err_o;
   logic              flush_i;
   logic [1:0]        trig_level_i;
   logic              clr_overrun_i;
   logic              empty_o;
   logic              full_o;
   logic [CW-1:0]     count_o;
   logic              overrun_o;
   logic              trig_o;
   logic              timeout_o;

   modport master (
      output wr_valid_i, wr_data_i, wr_frame_err_i, rd_pop_i, flush_i,
             trig_level_i, clr_overrun_i,
      input  rd_data_o, rd_frame_err_o, empty_o, full_o, count_o,
             overrun_o, trig_o, timeout_o
   );

   modport slave (
      input  wr_valid_i, wr_data_i, wr_frame_err_i, rd_pop_i, flush_i,
             trig_level_i, clr_overrun_i,
      output rd_data_o, rd_frame_err_o, empty_o, full_o, count_o,
             overrun_o, trig_o, timeout_o
   );
endinterface

// File: rtl/uart_ns_sync_fifo.sv
// Generic single-clock show-ahead FIFO with push, pop, flush and occupancy count.
// Full-and-both pushes and pops together; a pop on empty is ignored.
module uart_ns_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 9,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [W-1:0]  i_push_dat,
   input  logic          i_pop,
   input  logic          i_flush,
   output logic [W-1:0]  o_dat,
   output logic          o_empty,
   output logic          o_full,
   output logic [CW-1:0] o_count
);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_empty;
   logic          w_full;
   logic          w_do_push;
   logic          w_do_pop;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CW'(DEPTH));
   // When full, a simultaneous pop frees the head slot the push lands in.
   assign w_do_push = i_push && (!w_full || i_pop);
   assign w_do_pop  = i_pop && !w_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wptr] <= i_push_dat;
   end

   assign o_dat   = w_empty ? '0 : r_mem[r_rptr];
   assign o_empty = w_empty;
   assign o_full  = w_full;
   assign o_count = r_count;
endmodule

// File: rtl/uart_ns_rx_fifo.sv
// UART receive FIFO: byte+frame-error storage with trigger, overrun and character-timeout status.
// Full pushes without a pop are dropped and flag a sticky overrun.
module uart_ns_rx_fifo
   import uart_ns_rx_fifo_pkg::*;
#(
   parameter int DEPTH       = UART_RX_FIFO_DEPTH,
   parameter int DATA_W      = UART_DATA_SIZE,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_ns_rx_fifo_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [DATA_W:0] w_head;
   logic            w_empty;
   logic            w_full;
   logic [CW-1:0]   w_count;
   logic [CW-1:0]   w_lvl;
   logic            w_drop;
   logic            w_activity;
   logic            r_overrun;
   logic [TW-1:0]   r_to_cnt;

   uart_ns_sync_fifo #(
      .DEPTH (DEPTH),
      .W     (DATA_W + 1)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (bus.wr_valid_i),
      .i_push_dat ({bus.wr_frame_err_i, bus.wr_data_i}),
      .i_pop      (bus.rd_pop_i),
      .i_flush    (bus.flush_i),
      .o_dat      (w_head),
      .o_empty    (w_empty),
      .o_full     (w_full),
      .o_count    (w_count)
   );

   assign w_drop     = bus.wr_valid_i && !bus.rd_pop_i && !bus.flush_i && w_full;
   assign w_activity = bus.wr_valid_i || bus.rd_pop_i || bus.flush_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_overrun <= 1'b0;
      else if (w_drop)            r_overrun <= 1'b1;
      else if (bus.clr_overrun_i) r_overrun <= 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_to_cnt <= '0;
      else if (w_activity || w_empty)      r_to_cnt <= '0;
      else if (r_to_cnt != TW'(TIMEOUT_CYC)) r_to_cnt <= r_to_cnt + 1'b1;
   end

   always_comb begin
      w_lvl = CW'(trig_entries(type_uart_rx_trig_e'(bus.trig_level_i)));
      if (w_lvl > CW'(DEPTH)) w_lvl = CW'(DEPTH);
   end

   assign bus.rd_data_o      = w_head[DATA_W-1:0];
   assign bus.rd_frame_err_o = w_head[DATA_W];
   assign bus.empty_o        = w_empty;
   assign bus.full_o         = w_full;
   assign bus.count_o        = w_count;
   assign bus.overrun_o      = r_overrun;
   assign bus.trig_o         = (w_count >= w_lvl);
   assign bus.timeout_o      = (r_to_cnt == TW'(TIMEOUT_CYC)) && !w_empty;
endmodule

// File: tb/tb_uart_ns_rx_fifo.sv
// Directed bench for the UART receive FIFO: vector table plus full, timeout and reset sequences.
module tb_uart_ns_rx_fifo;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   uart_ns_rx_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();

   uart_ns_rx_fifo #(.DEPTH(16), .DATA_W(8), .TIMEOUT_CYC(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       push;
      logic [7:0] dat;
      logic       fe;
      logic       pop;
      logic       flush;
      logic [1:0] trig;
      logic       clr;
      int         e_cnt;
      logic       e_ovr;
      logic       e_trig;
      logic [7:0] e_head;
      logic       e_fe;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic push, input logic [7:0] dat, input logic fe,
                               input logic pop, input logic flush, input logic [1:0] trig,
                               input logic clr, input int e_cnt, input logic e_ovr,
                               input logic e_trig, input logic [7:0] e_head, input logic e_fe);
      vec_t v;
      v.push = push; v.dat = dat; v.fe = fe; v.pop = pop; v.flush = flush;
      v.trig = trig; v.clr = clr; v.e_cnt = e_cnt; v.e_ovr = e_ovr;
      v.e_trig = e_trig; v.e_head = e_head; v.e_fe = e_fe;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic push, input logic [7:0] dat, input logic fe,
                       input logic pop, input logic flush, input logic clr);
      bus.wr_valid_i     = push;
      bus.wr_data_i      = dat;
      bus.wr_frame_err_i = fe;
      bus.rd_pop_i       = pop;
      bus.flush_i        = flush;
      bus.clr_overrun_i  = clr;
      @(posedge clk);
      #1;
      bus.wr_valid_i     = 1'b0;
      bus.rd_pop_i       = 1'b0;
      bus.flush_i        = 1'b0;
      bus.clr_overrun_i  = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_q[$];
      logic [7:0] b;
      total = 0;
      bad   = 0;

      // Vector table
      add(1, 8'hA5, 0, 0, 0, 2'd0, 0, 1, 0, 1, 8'hA5, 0);
      add(0, 8'h00, 0, 1, 0, 2'd0, 0, 0, 0, 0, 8'h00, 0);
      add(1, 8'h3C, 1, 0, 0, 2'd0, 0, 1, 0, 1, 8'h3C, 1);
      add(1, 8'h11, 0, 1, 0, 2'd0, 0, 1, 0, 1, 8'h11, 0);
      add(0, 8'h00, 0, 1, 0, 2'd0, 0, 0, 0, 0, 8'h00, 0);
      add(0, 8'h00, 0, 1, 0, 2'd0, 0, 0, 0, 0, 8'h00, 0);
      add(1, 8'h22, 0, 1, 0, 2'd0, 0, 1, 0, 1, 8'h22, 0);
      add(0, 8'h00, 0, 1, 0, 2'd0, 0, 0, 0, 0, 8'h00, 0);
      for (int i = 0; i < 16; i++)
         add(1, 8'(i), 1'(i % 2), 0, 0, 2'd3, 0, i + 1, 0, (i + 1 >= 14), 8'h00, 0);
      add(1, 8'h55, 1, 0, 0, 2'd3, 0, 16, 1, 1, 8'h00, 0);
      for (int j = 0; j < 16; j++)
         add(0, 8'h00, 0, 1, 0, 2'd3, 0, 15 - j, 1, (15 - j >= 14),
             (j < 15) ? 8'(j + 1) : 8'h00, (j < 15) ? 1'((j + 1) % 2) : 1'b0);
      for (int i = 0; i < 5; i++)
         add(1, 8'(8'h40 + i), 0, 0, 0, 2'd1, 0, i + 1, 1, (i + 1 >= 4), 8'h40, 0);
      add(1, 8'h99, 1, 0, 1, 2'd1, 0, 0, 1, 0, 8'h00, 0);
      add(0, 8'h00, 0, 0, 0, 2'd1, 1, 0, 0, 0, 8'h00, 0);
      for (int i = 0; i < 8; i++)
         add(1, 8'(8'h80 + i), 0, 0, 0, 2'd2, 0, i + 1, 0, (i + 1 >= 8), 8'h80, 0);
      add(0, 8'h00, 0, 1, 0, 2'd2, 0, 7, 0, 0, 8'h81, 0);
      add(0, 8'h00, 0, 0, 1, 2'd2, 0, 0, 0, 0, 8'h00, 0);

      bus.wr_valid_i = 0; bus.wr_data_i = 0; bus.wr_frame_err_i = 0;
      bus.rd_pop_i = 0; bus.flush_i = 0; bus.trig_level_i = 2'd0; bus.clr_overrun_i = 0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      chk("rst_empty",   32'(bus.empty_o), 1);
      chk("rst_full",    32'(bus.full_o), 0);
      chk("rst_count",   32'(bus.count_o), 0);
      chk("rst_overrun", 32'(bus.overrun_o), 0);
      chk("rst_trig",    32'(bus.trig_o), 0);
      chk("rst_timeout", 32'(bus.timeout_o), 0);
      chk("rst_data",    32'(bus.rd_data_o), 0);
      chk("rst_ferr",    32'(bus.rd_frame_err_o), 0);

      foreach (vecs[k]) begin
         bus.trig_level_i = vecs[k].trig;
         step(vecs[k].push, vecs[k].dat, vecs[k].fe, vecs[k].pop, vecs[k].flush, vecs[k].clr);
         chk($sformatf("v%0d_count", k),   32'(bus.count_o), 32'(vecs[k].e_cnt));
         chk($sformatf("v%0d_empty", k),   32'(bus.empty_o), 32'(vecs[k].e_cnt == 0));
         chk($sformatf("v%0d_full", k),    32'(bus.full_o), 32'(vecs[k].e_cnt == 16));
         chk($sformatf("v%0d_overrun", k), 32'(bus.overrun_o), 32'(vecs[k].e_ovr));
         chk($sformatf("v%0d_trig", k),    32'(bus.trig_o), 32'(vecs[k].e_trig));
         chk($sformatf("v%0d_head", k),    32'(bus.rd_data_o), 32'(vecs[k].e_head));
         chk($sformatf("v%0d_ferr", k),    32'(bus.rd_frame_err_o), 32'(vecs[k].e_fe));
         chk($sformatf("v%0d_timeout", k), 32'(bus.timeout_o), 0);
      end

      // Full FIFO: push+pop together, then a dropped push with a same-cycle clear
      bus.trig_level_i = 2'd0;
      for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0, 0);
      chk("full_fill_count", 32'(bus.count_o), 16);
      step(1, 8'h77, 0, 1, 0, 0);
      chk("full_pp_count",   32'(bus.count_o), 16);
      chk("full_pp_full",    32'(bus.full_o), 1);
      chk("full_pp_overrun", 32'(bus.overrun_o), 0);
      chk("full_pp_head",    32'(bus.rd_data_o), 32'h01);
      step(1, 8'h88, 0, 0, 0, 1);
      chk("set_over_clr",    32'(bus.overrun_o), 1);
      chk("drop_count",      32'(bus.count_o), 16);
      for (int i = 1; i < 16; i++) exp_q.push_back(8'(i));
      exp_q.push_back(8'h77);
      foreach (exp_q[k]) begin
         b = exp_q[k];
         chk($sformatf("drain%0d_head", k), 32'(bus.rd_data_o), 32'(b));
         step(0, 8'h00, 0, 1, 0, 0);
      end
      chk("drain_empty", 32'(bus.empty_o), 1);
      step(0, 8'h00, 0, 0, 0, 1);
      chk("drain_clr_overrun", 32'(bus.overrun_o), 0);

      // Character timeout
      step(1, 8'hC1, 0, 0, 0, 0);
      step(1, 8'hC2, 0, 0, 0, 0);
      for (int k = 1; k <= 32; k++) begin
         step(0, 8'h00, 0, 0, 0, 0);
         chk($sformatf("to_a%0d", k), 32'(bus.timeout_o), 32'(k == 32));
      end
      step(0, 8'h00, 0, 0, 0, 0);
      chk("to_saturate", 32'(bus.timeout_o), 1);
      step(0, 8'h00, 0, 1, 0, 0);
      chk("to_pop_clear", 32'(bus.timeout_o), 0);
      chk("to_pop_count", 32'(bus.count_o), 1);
      chk("to_pop_head",  32'(bus.rd_data_o), 32'hC2);
      for (int k = 1; k <= 32; k++) begin
         step(0, 8'h00, 0, 0, 0, 0);
         chk($sformatf("to_b%0d", k), 32'(bus.timeout_o), 32'(k == 32));
      end
      step(0, 8'h00, 0, 0, 1, 0);
      chk("to_flush_clear", 32'(bus.timeout_o), 0);
      chk("to_flush_empty", 32'(bus.empty_o), 1);

      // Asynchronous reset mid-operation
      for (int i = 0; i < 3; i++) step(1, 8'(8'hD0 + i), 1, 0, 0, 0);
      chk("pre_arst_count", 32'(bus.count_o), 3);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", 32'(bus.count_o), 0);
      chk("arst_empty", 32'(bus.empty_o), 1);
      chk("arst_data",  32'(bus.rd_data_o), 0);
      chk("arst_ferr",  32'(bus.rd_frame_err_o), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(0, 8'h00, 0, 0, 0, 0);
      chk("post_arst_empty", 32'(bus.empty_o), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
